// File: rtl/sisc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sisc_pkg
// Description : Shared types and defaults for the memory arbiter: FSM state
//               encoding, port-owner encoding and default bus widths.
// Revision    : 1.0 - initial release
// ============================================================================
package sisc_pkg;

    localparam int c_ADDR_W = 16;
    localparam int c_DATA_W = 32;

    localparam logic c_OWNER_IF = 1'b0;
    localparam logic c_OWNER_DM = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb
// Description : Arbitrates instruction-fetch and data-memory requests onto one
//               single-port memory with fixed read latency MEM_LAT (1..7).
//               Define MEM_ARB_FAIRNESS_EN for round-robin arbitration;
//               otherwise the data port has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb #(
    parameter int MEM_LAT = 1,
    parameter int ADDR_W  = sisc_pkg::c_ADDR_W,
    parameter int DATA_W  = sisc_pkg::c_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    import sisc_pkg::*;

    localparam logic [2:0] c_LAT_M1 = 3'(MEM_LAT - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_owner;
    logic [2:0] r_cnt;
    logic       r_we;
    logic       w_any_req;
    logic       w_grant_dm;
    logic       w_issue;
    logic       w_done;
    logic       w_owner_dm;

    assign w_any_req = if_req | dm_req;

`ifdef MEM_ARB_FAIRNESS_EN
    // Last-granted port; a tie goes to the other one.
    logic r_last;

    always_comb begin
        w_grant_dm = dm_req;
        if (if_req && dm_req) begin
            w_grant_dm = (r_last == c_OWNER_IF);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= c_OWNER_IF;
        end else if (r_state == ST_IDLE && w_any_req) begin
            r_last <= w_grant_dm ? c_OWNER_DM : c_OWNER_IF;
        end
    end
`else
    assign w_grant_dm = dm_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_owner <= c_OWNER_IF;
            r_cnt   <= 3'd0;
            r_we    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_grant_dm ? c_OWNER_DM : c_OWNER_IF;
                    end
                end
                ST_ISSUE: begin
                    r_cnt <= c_LAT_M1;
                    r_we  <= mem_we;
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_any_req) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = (MEM_LAT > 1) ? ST_WAIT : ST_DONE;
            // The counter still holds 1 in the last wait cycle.
            ST_WAIT:  if (r_cnt <= 3'd1) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_issue    = (r_state == ST_ISSUE);
    assign w_done     = (r_state == ST_DONE);
    assign w_owner_dm = (r_owner == c_OWNER_DM);

    // Address and data reach the memory only during ISSUE.
    assign mem_en    = w_issue;
    assign mem_we    = w_issue & w_owner_dm & dm_we;
    assign mem_addr  = w_issue ? (w_owner_dm ? dm_addr : if_addr) : '0;
    assign mem_wdata = (w_issue & w_owner_dm) ? dm_wdata : '0;

    assign if_done  = w_done & ~w_owner_dm;
    assign dm_done  = w_done & w_owner_dm;
    assign if_rdata = if_done ? mem_rdata : '0;
    assign dm_rdata = (dm_done & ~r_we) ? mem_rdata : '0;
    assign busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter MEM_LAT, default 1: memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..7.
REQ-002 Parameter ADDR_W, default 16: address width.
REQ-003 Parameter DATA_W, default 32: data width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 if_req  in  1  instruction-fetch request; held until if_done.
REQ-007 if_addr  in  ADDR_W  fetch address (PC); stable while if_req is high.
REQ-008 if_rdata  out  DATA_W  fetched instruction; valid only in the if_done cycle.
REQ-009 if_done  out  1  one-cycle pulse: fetch complete.
REQ-010 dm_req  in  1  data-memory request; held until dm_done.
REQ-011 dm_we  in  1  1 = store, 0 = load; stable while dm_req is high.
REQ-012 dm_addr  in  ADDR_W  data address.
REQ-013 dm_wdata  in  DATA_W  store data.
REQ-014 dm_rdata  out  DATA_W  load data; valid only in the dm_done cycle.
REQ-015 dm_done  out  1  one-cycle pulse: load or store complete.
REQ-016 mem_en  out  1  single-port memory access strobe, one cycle per transaction.
REQ-017 mem_we  out  1  memory write enable; asserted only together with mem_en.
REQ-018 mem_addr  out  ADDR_W  memory address.
REQ-019 mem_wdata  out  DATA_W  memory write data.
REQ-020 mem_rdata  in  DATA_W  memory read data.
REQ-021 busy  out  1  high in every state other than IDLE.

Function
REQ-022 FSM states: IDLE, ISSUE, WAIT, DONE. Transitions:
- IDLE -> ISSUE when any request is high.
- ISSUE -> WAIT when MEM_LAT > 1, otherwise ISSUE -> DONE.
- WAIT -> DONE when the latency counter expires.
- DONE -> IDLE, unconditionally.
REQ-023 Grant decision:
- The owner (IF or DM) is latched in IDLE at the cycle t where a request is seen.
- mem_en pulses in cycle t+1 (ISSUE), with mem_addr, mem_we and mem_wdata taken from the owner.
REQ-024 The latency counter loads MEM_LAT-1 in ISSUE and decrements in WAIT; DONE is entered on the cycle mem_rdata is valid, i.e. cycle t+1+MEM_LAT.
REQ-025 In DONE:
- the owner's done pulses for exactly one cycle;
- its rdata presents mem_rdata for loads and fetches, and 0 for stores.
REQ-026 Minimum request-to-done latency is MEM_LAT+1 cycles; back-to-back transaction period is MEM_LAT+2 cycles.
REQ-027 Default arbitration is fixed priority: on simultaneous if_req and dm_req in IDLE, DM wins. IF is served in the first IDLE cycle where dm_req is low.
REQ-028 A requester holds its req through the done cycle and drops it in the next cycle. A req still high in IDLE after done starts a new transaction.
REQ-029 A request dropped mid-transaction does not abort it: the memory access completes and done still pulses.
REQ-030 Address and write data are sampled only in ISSUE; changes after ISSUE have no effect.
REQ-031 The non-owner's done output stays 0 for the whole transaction.

Reset
REQ-032 rst high at a clock edge forces:
- FSM to IDLE, counter to 0, owner to IF;
- mem_en, mem_we, if_done, dm_done and busy to 0;
- mem_addr, mem_wdata, if_rdata and dm_rdata to 0.
REQ-033 Reset mid-transaction aborts it: no done pulse is issued, and no mem_en is issued in the cycle after reset.

Configuration
REQ-034 Macro MEM_ARB_FAIRNESS_EN selects the arbitration policy:
- Defined: round-robin. On simultaneous requests the port not granted last wins; the last-granted record resets to IF, so DM wins the first tie.
- Undefined: fixed DM priority per REQ-027.

Structure
REQ-035 The FSM state enum, the owner encoding (IF=0, DM=1) and the ADDR_W/DATA_W defaults are defined in shared package sisc_pkg.
REQ-036 The block is a single module with no sub-modules; arbitration logic is inline.

Verification
REQ-037 Single fetch, MEM_LAT=1: if_req with if_addr=0x0010 and mem_rdata=0x12345678 -> mem_en at t+1 with mem_addr=0x0010; if_done with if_rdata=0x12345678 at t+2.
REQ-038 Store: dm_req, dm_we=1, dm_addr=0x0040, dm_wdata=0xDEADBEEF -> one mem_en/mem_we cycle with those values; dm_done=1 and dm_rdata=0.
REQ-039 Simultaneous if_req and dm_req held:
- Default build: DM is served first, then IF; if_done arrives exactly MEM_LAT+2 cycles after dm_done.
- With MEM_ARB_FAIRNESS_EN: two repeated ties grant DM then IF.
REQ-040 MEM_LAT=3 load: mem_en at t+1 and dm_done at t+4; busy is high for cycles t+1..t+4.
REQ-041 rst asserted in the WAIT cycle of a load -> no dm_done, busy=0 and all outputs 0 the next cycle; a subsequent if_req completes normally.
REQ-042 dm_req dropped after ISSUE -> dm_done still pulses on schedule, and no second mem_en occurs.
